// File: rtl/csel_pkg.sv
// rtl/csel_pkg.sv - shared constants, payload type and depth helper for the carry-select pipe adder.
// Optional feature macro: CSEL_PIPE_OVF_EN (adds the ovf bit to the payload).
package csel_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_BLK         = 4;
  localparam int DEF_BLK_PER_STG = 1;

  // Payload layout at the default width; the top re-declares it at its own WIDTH.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 carry;
`ifdef CSEL_PIPE_OVF_EN
    logic                 ovf;
`endif
    logic                 valid;
  } csel_stage_t;

  function automatic int csel_stages(input int width, input int blk, input int blk_per_stg);
    return width / (blk * blk_per_stg);
  endfunction

endpackage

// File: rtl/csel_pipe_adder_if.sv
// rtl/csel_pipe_adder_if.sv - operand/result handshake bundle for csel_pipe_adder.
// Optional feature macro: CSEL_PIPE_OVF_EN (adds out_ovf).
interface csel_pipe_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
`ifdef CSEL_PIPE_OVF_EN
  logic             out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef CSEL_PIPE_OVF_EN
    input  out_ovf,
`endif
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
`ifdef CSEL_PIPE_OVF_EN
    output out_ovf,
`endif
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/csel_group.sv
// rtl/csel_group.sv - combinational BLK-bit carry-select group.
module csel_group #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           c,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] r0;
  logic [BLK:0] r1;

  // Both carry-in hypotheses are computed up front; c only steers the mux.
  assign r0   = {1'b0, a} + {1'b0, b};
  assign r1   = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
  assign sum  = c ? r1[BLK-1:0] : r0[BLK-1:0];
  assign cout = r0[BLK] | (c & r1[BLK]);

endmodule

// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - pipelined carry-select adder/subtractor, BLK_PER_STG groups per stage.
// Optional feature macro: CSEL_PIPE_OVF_EN (signed overflow output out_ovf).
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BLK         = DEF_BLK,
  parameter int BLK_PER_STG = DEF_BLK_PER_STG
) (
  input logic               clk,
  input logic               rst_n,
  csel_pipe_adder_if.slave  bus
);

  localparam int SB     = BLK * BLK_PER_STG;
  localparam int STAGES = csel_stages(WIDTH, BLK, BLK_PER_STG);

  if ((BLK < 1) || (BLK_PER_STG < 1) || (WIDTH % SB != 0) || (STAGES < 1)) begin : g_bad_cfg
    $error("csel_pipe_adder: WIDTH must be a non-zero multiple of BLK*BLK_PER_STG");
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
`ifdef CSEL_PIPE_OVF_EN
    logic             ovf;
`endif
    logic             valid;
  } stage_t;

  logic   adv;
  stage_t in_beat;

  // Subtraction folds into the operand: invert B once, force carry-in high.
  always_comb begin
    in_beat       = '0;
    in_beat.a     = bus.in_a;
    in_beat.b     = bus.in_sub ? ~bus.in_b : bus.in_b;
    in_beat.carry = bus.in_sub | bus.in_cin;
    in_beat.valid = bus.in_valid;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stage_t                 src;
    stage_t                 nxt;
    stage_t                 q;
    logic [BLK_PER_STG:0]   c;
    logic [SB-1:0]          grp_sum;

    if (k == 0) begin : g_first
      assign src = in_beat;
    end else begin : g_next
      assign src = g_stg[k-1].q;
    end

    assign c[0] = src.carry;

    for (genvar g = 0; g < BLK_PER_STG; g++) begin : g_grp
      csel_group #(.BLK(BLK)) u_grp (
        .a    (src.a[k*SB + g*BLK +: BLK]),
        .b    (src.b[k*SB + g*BLK +: BLK]),
        .c    (c[g]),
        .sum  (grp_sum[g*BLK +: BLK]),
        .cout (c[g+1])
      );
    end

    always_comb begin
      nxt                    = src;
      nxt.sum[k*SB +: SB]    = grp_sum;
      nxt.carry              = c[BLK_PER_STG];
`ifdef CSEL_PIPE_OVF_EN
      // Carry into the MSB is recovered as a^b^sum at that bit.
      if (k == STAGES - 1) begin
        nxt.ovf = src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ grp_sum[SB-1] ^ c[BLK_PER_STG];
      end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end
  end

  assign adv           = !g_stg[STAGES-1].q.valid | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stg[STAGES-1].q.valid;
  assign bus.out_sum   = g_stg[STAGES-1].q.sum;
  assign bus.out_cout  = g_stg[STAGES-1].q.carry;
`ifdef CSEL_PIPE_OVF_EN
  assign bus.out_ovf   = g_stg[STAGES-1].q.ovf;
`endif

endmodule
